instr_loader: RTL
=================

Name: instr_loader

Overview:
- Writer side of the instruction memory, which the core only ever reads.
- Receives a program as a byte stream using a valid/ready handshake.
- Assembles bytes little-endian into 32-bit instruction words and issues one write per word into instruction memory. Word 0 goes to byte address 0, and addresses increment by 4.
- Holds the core in reset while loading and signals done or error afterwards.
- Sits beside the core top, between an external host link (UART/JTAG bridge) and the instruction memory write port.

Parameters:
- ADDR_WIDTH_POW, 6: address width = 1 << ADDR_WIDTH_POW (64 bits).
- INSTR_MEM_DEPTH_POW, 10: instruction memory depth = 2^INSTR_MEM_DEPTH_POW words (1024).

Ports:
- clk_in, input, 1: single clock; all state changes on its rising edge.
- reset, input, 1: reset; synchronous, active-low.
- start_in, input, 1: one-cycle pulse that begins a load; sampled only in IDLE, DONE and ERROR.
- wordCount_in, input, INSTR_MEM_DEPTH_POW+1: number of words to load; sampled on the accepted start_in.
- byte_valid_in, input, 1: byte_in holds a valid byte.
- byte_in, input, 8: stream byte.
- byte_ready_out, output, 1: loader can accept a byte this cycle.
- memWrite_out, output, 1: instruction memory write strobe; one cycle per word.
- memAddr_out, output, ADDR_WIDTH: byte address of the write (word index * 4).
- memData_out, output, 32: instruction word to write.
- coreHold_out, output, 1: high while loading; drives the core's reset.
- busy_out, output, 1: high in RECV and WRITE.
- done_out, output, 1: load completed successfully; level signal.
- error_out, output, 1: load rejected; level signal.

Behaviour:
- States: IDLE, RECV, WRITE, DONE, ERROR.
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - Byte counter, word counter and assembly register clear to 0.
  - All outputs go to 0.
  - Reset mid-load discards any partial word and issues no write. The next load restarts at address 0.
- IDLE/DONE/ERROR with start_in==1:
  - If wordCount_in==0 or wordCount_in > 2^INSTR_MEM_DEPTH_POW, go to ERROR. error_out=1, no writes.
  - Otherwise latch wordCount_in, clear the counters, clear done_out and error_out, and go to RECV.
- DONE and ERROR hold their flag until the next accepted start_in or reset. start_in in RECV/WRITE is ignored.
- RECV:
  - byte_ready_out=1. A byte transfers on an edge with byte_valid_in && byte_ready_out.
  - Byte k of a word (k = 0..3) goes to bits [8k+7:8k], so the first byte received is the least significant.
  - When the 4th byte is accepted, go to WRITE.
  - Bytes presented while byte_ready_out==0 are not consumed; the sender holds them.
- WRITE (exactly 1 cycle):
  - memWrite_out=1, memAddr_out = wordIdx<<2 (zero-extended to ADDR_WIDTH), memData_out = assembled word. byte_ready_out=0.
  - Next state is DONE if wordIdx == count-1, otherwise RECV with wordIdx incremented.
- Latency:
  - The 4th byte accepted at edge N gives memWrite_out high during cycle N+1.
  - The earliest next byte is accepted at edge N+2, so peak throughput is 4 bytes per 5 cycles.
  - The final write in cycle N+1 gives done_out=1 from cycle N+2.
- coreHold_out:
  - Equals 1 in RECV and WRITE, 0 otherwise.
  - It deasserts in the same cycle done_out asserts.
- memAddr_out and memData_out:
  - Valid only when memWrite_out==1.
  - Outside WRITE they are held at their last value. The bench must not check them.
- Arithmetic:
  - wordIdx is INSTR_MEM_DEPTH_POW+1 bits wide and never wraps because of the count check.
  - At full depth the last address is (2^INSTR_MEM_DEPTH_POW - 1)*4.

Test Plan:
1. Basic load:
   - Stimulus: start_in with wordCount_in=2, then continuous bytes 13 05 50 00 93 05 A0 00 (hex).
   - Required: write addr 0x0 data 0x00500513, then addr 0x4 data 0x00A00593. Exactly 2 memWrite_out pulses. done_out=1 and coreHold_out=0 two cycles after the last byte.
2. Gapped source:
   - Stimulus: same data with byte_valid_in toggled randomly, and byte_valid_in held high during the WRITE cycles.
   - Required: same two writes. No byte lost or duplicated. byte_ready_out=0 in each WRITE cycle.
3. Bad count:
   - Stimulus: wordCount_in=0, then wordCount_in=1025 (depth 10).
   - Required: error_out=1, no memWrite_out. A later valid start with wordCount_in=1 clears error_out and loads normally.
4. Reset mid-word:
   - Stimulus: after 2 of 4 bytes, drive reset=0 for 1 cycle.
   - Required: no write, all outputs 0, state IDLE. A new load of 1 word writes addr 0x0.
5. Ignored inputs:
   - Stimulus: start_in pulsed during RECV; byte_valid_in with data in IDLE.
   - Required: load count unchanged; IDLE bytes not consumed (byte_ready_out=0); no writes.
6. Full depth:
   - Stimulus: wordCount_in=1024 with an incrementing word pattern.
   - Required: 1024 writes, last at addr 0xFFC, then done_out=1.

Source files
------------

// File: rtl/instr_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them from address 0 upward, and holds the core in reset meanwhile.
module instr_loader #(
    parameter int unsigned ADDR_WIDTH_POW      = 6,
    parameter int unsigned INSTR_MEM_DEPTH_POW = 10
) (
    input  logic                                clk_in,
    input  logic                                reset,
    input  logic                                start_in,
    input  logic [INSTR_MEM_DEPTH_POW:0]        wordCount_in,
    input  logic                                byte_valid_in,
    input  logic [7:0]                          byte_in,
    output logic                                byte_ready_out,
    output logic                                memWrite_out,
    output logic [(1 << ADDR_WIDTH_POW) - 1:0]  memAddr_out,
    output logic [31:0]                         memData_out,
    output logic                                coreHold_out,
    output logic                                busy_out,
    output logic                                done_out,
    output logic                                error_out
);

    localparam int unsigned ADDR_WIDTH = 1 << ADDR_WIDTH_POW;
    localparam int unsigned CW         = INSTR_MEM_DEPTH_POW + 1;
    localparam logic [CW-1:0] MAX_WORDS = {1'b1, {INSTR_MEM_DEPTH_POW{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q;
    logic [CW-1:0]           count_q;
    logic [CW-1:0]           wordIdx_q;
    logic [1:0]              byteCnt_q;
    logic [23:0]             asm_q;
    logic                    byteReady_q;
    logic                    memWrite_q;
    logic [ADDR_WIDTH-1:0]   memAddr_q;
    logic [31:0]             memData_q;
    logic                    coreHold_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            wordIdx_q   <= '0;
            byteCnt_q   <= '0;
            asm_q       <= '0;
            byteReady_q <= 1'b0;
            memWrite_q  <= 1'b0;
            memAddr_q   <= '0;
            memData_q   <= '0;
            coreHold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            memWrite_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start_in) begin
                        if (wordCount_in == '0 || wordCount_in > MAX_WORDS) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                            done_q  <= 1'b0;
                        end else begin
                            state_q     <= S_RECV;
                            count_q     <= wordCount_in;
                            wordIdx_q   <= '0;
                            byteCnt_q   <= '0;
                            asm_q       <= '0;
                            done_q      <= 1'b0;
                            error_q     <= 1'b0;
                            byteReady_q <= 1'b1;
                            coreHold_q  <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (byte_valid_in && byteReady_q) begin
                        // Shift right so the first byte ends up least significant.
                        asm_q     <= {byte_in, asm_q[23:8]};
                        byteCnt_q <= byteCnt_q + 2'd1;
                        if (byteCnt_q == 2'd3) begin
                            state_q     <= S_WRITE;
                            byteReady_q <= 1'b0;
                            memWrite_q  <= 1'b1;
                            memAddr_q   <= {{(ADDR_WIDTH - CW - 2){1'b0}}, wordIdx_q, 2'b00};
                            memData_q   <= {byte_in, asm_q};
                        end
                    end
                end
                S_WRITE: begin
                    if (wordIdx_q == count_q - 1'b1) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        coreHold_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end else begin
                        state_q     <= S_RECV;
                        wordIdx_q   <= wordIdx_q + 1'b1;
                        byteReady_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign byte_ready_out = byteReady_q;
    assign memWrite_out   = memWrite_q;
    assign memAddr_out    = memAddr_q;
    assign memData_out    = memData_q;
    assign coreHold_out   = coreHold_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign error_out      = error_q;

endmodule
